// File: rtl/ps2_frame_sequencer_pkg.sv
// ps2_frame_sequencer_pkg
//   Shared definitions for the PS/2 receive path:
//   - frame geometry and bit positions,
//   - the E0/F0 prefix codes,
//   - FSM state encodings,
//   - the held-event payload and the frame validity check.
package ps2_frame_sequencer_pkg;

    localparam int unsigned FRAME_BITS   = 11;
    localparam int unsigned FRAME_START  = 0;
    localparam int unsigned FRAME_PARITY = 9;
    localparam int unsigned FRAME_STOP   = 10;
    localparam int unsigned BITCNT_W     = 4;

    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    // One scancode event as presented to the consumer
    typedef struct packed {
        logic [FRAME_BITS-1:0] frame;
        logic                  is_break;
        logic                  is_extended;
    } ps2_event_t;

    // Start low, stop high, odd parity over data+parity
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
        return (f[FRAME_START] == 1'b0) &&
               (f[FRAME_STOP] == 1'b1) &&
               ((^f[FRAME_PARITY:1]) == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge
//   Brings the raw PS/2 clock and data pins into the system clock domain
//   and detects falling edges of the keyboard clock.
//
//   Optional build macro: PS2_GLITCH_FILTER_EN
//     When defined, the synced clock level must hold for FILTER_LEN
//     consecutive cycles before the edge detector sees it.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   ps2_clk    in   raw keyboard clock (asynchronous)
//   ps2_dat    in   raw keyboard data (asynchronous)
//   fall_pulse out  one-cycle pulse on a synced clock 1->0 transition
//   data_bit   out  synced data, valid to sample with fall_pulse
module ps2_sync_edge
    import ps2_frame_sequencer_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic fall_pulse,
    output logic data_bit
);

    if (FILTER_LEN == 0) begin : g_bad_filter_len
        $error("FILTER_LEN must be at least 1");
    end

    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       clk_level;
    logic       clk_prev;

    // Two-flop synchronisers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '0;
            dat_sync <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
        end
    end

`ifdef PS2_GLITCH_FILTER_EN
    localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);

    logic [FILT_W-1:0] filt_cnt;
    logic              filt_level;

    // Accept a new clock level only after it has held FILTER_LEN cycles.
    // Data is not delayed: PS/2 data is stable for most of the low phase,
    // far longer than the filter delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt   <= '0;
            filt_level <= 1'b0;
        end else if (clk_sync[1] == filt_level) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
            filt_level <= clk_sync[1];
            filt_cnt   <= '0;
        end else begin
            filt_cnt <= filt_cnt + FILT_W'(1);
        end
    end

    assign clk_level = filt_level;
`else
    assign clk_level = clk_sync[1];
`endif

    // Previous level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_prev <= 1'b0;
        end else begin
            clk_prev <= clk_level;
        end
    end

    assign fall_pulse = clk_prev & ~clk_level;
    assign data_bit   = dat_sync[1];

endmodule

// File: rtl/ps2_frame_sequencer.sv
// ps2_frame_sequencer
//   PS/2 keyboard receive controller.
//   - Captures 11-bit frames and validates start, parity and stop.
//   - Folds E0/F0 prefixes into flags.
//   - Holds one scancode event at a time behind a valid/ack handshake.
//
//   Optional build macro: PS2_GLITCH_FILTER_EN (clock glitch filter,
//   FILTER_LEN cycles, implemented in ps2_sync_edge).
//
// Ports:
//   CLOCK_50    in   system clock
//   resetn      in   asynchronous active-low reset
//   PS2_CLK     in   raw keyboard clock
//   PS2_DAT     in   raw keyboard data
//   code_ack    in   consumer accepts the held event
//   code_valid  out  event held on the outputs
//   frame       out  last accepted frame (start, data LSB-first, parity, stop)
//   scancode    out  frame[8:1]
//   is_break    out  F0 preceded this code
//   is_extended out  E0 preceded this code
//   frame_err   out  one-cycle pulse on a bad frame or timeout
//   overrun     out  sticky, set when an event was dropped
module ps2_frame_sequencer
    import ps2_frame_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    input  logic        code_ack,
    output logic        code_valid,
    output logic [10:0] frame,
    output logic [7:0]  scancode,
    output logic        is_break,
    output logic        is_extended,
    output logic        frame_err,
    output logic        overrun
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic fall_pulse;
    logic data_bit;

    ps2_sync_edge #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sync_edge (
        .clk        (CLOCK_50),
        .rst_n      (resetn),
        .ps2_clk    (PS2_CLK),
        .ps2_dat    (PS2_DAT),
        .fall_pulse (fall_pulse),
        .data_bit   (data_bit)
    );

    state_t                state_q,   state_d;
    logic [BITCNT_W-1:0]   bitcnt_q,  bitcnt_d;
    logic [TMO_W-1:0]      tmo_q,     tmo_d;
    logic [FRAME_BITS-1:0] shreg_q,   shreg_d;
    logic                  ext_q,     ext_d;
    logic                  brk_q,     brk_d;
    ps2_event_t            evt_q,     evt_d;
    logic                  valid_q,   valid_d;
    logic                  err_q,     err_d;
    logic                  overrun_q, overrun_d;

    // State and datapath registers
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            tmo_q     <= '0;
            shreg_q   <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            evt_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            tmo_q     <= tmo_d;
            shreg_q   <= shreg_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            evt_q     <= evt_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        tmo_d     = tmo_q;
        shreg_d   = shreg_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        evt_d     = evt_q;
        valid_d   = valid_q;
        err_d     = 1'b0;
        overrun_d = overrun_q;

        // Accepted event is released; a delivery below may reload it
        if (valid_q && code_ack) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (fall_pulse && !data_bit) begin
                    shreg_d  = {data_bit, shreg_q[FRAME_BITS-1:1]};
                    bitcnt_d = BITCNT_W'(1);
                    state_d  = RECV;
                end
            end

            RECV: begin
                if (fall_pulse) begin
                    // Bits arrive LSB first; shifting right leaves start at [0]
                    shreg_d  = {data_bit, shreg_q[FRAME_BITS-1:1]};
                    bitcnt_d = bitcnt_q + BITCNT_W'(1);
                    tmo_d    = '0;
                    if (bitcnt_q == BITCNT_W'(FRAME_BITS - 1)) begin
                        state_d = CHECK;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
                    err_d    = 1'b1;
                    ext_d    = 1'b0;
                    brk_d    = 1'b0;
                    bitcnt_d = '0;
                    tmo_d    = '0;
                    state_d  = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            CHECK: begin
                state_d  = IDLE;
                bitcnt_d = '0;
                if (!frame_ok(shreg_q)) begin
                    err_d = 1'b1;
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end else if (shreg_q[8:1] == PS2_PREFIX_EXT) begin
                    ext_d = 1'b1;
                end else if (shreg_q[8:1] == PS2_PREFIX_BREAK) begin
                    brk_d = 1'b1;
                end else begin
                    if (!valid_q || code_ack) begin
                        evt_d.frame       = shreg_q;
                        evt_d.is_break    = brk_q;
                        evt_d.is_extended = ext_q;
                        valid_d           = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign code_valid  = valid_q;
    assign frame       = evt_q.frame;
    assign scancode    = evt_q.frame[8:1];
    assign is_break    = evt_q.is_break;
    assign is_extended = evt_q.is_extended;
    assign frame_err   = err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_ps2_frame_sequencer.sv
// tb_ps2_frame_sequencer
//   Directed bench: drives PS/2 frames bit by bit and compares the
//   decoded events against hand-computed frames.
module tb_ps2_frame_sequencer;

    localparam int unsigned TMO  = 200;
    localparam int unsigned HALF = 20;

    // Hand-computed frames {stop, parity, data[7:0], start}
    localparam logic [10:0] F_23     = 11'h446;
    localparam logic [10:0] F_4B     = 11'h696;
    localparam logic [10:0] F_F0     = 11'h7E0;
    localparam logic [10:0] F_E0     = 11'h5C0;
    localparam logic [10:0] F_75     = 11'h4EA;
    localparam logic [10:0] F_23_BAD = 11'h646;

    logic        CLOCK_50 = 1'b0;
    logic        resetn   = 1'b0;
    logic        PS2_CLK  = 1'b1;
    logic        PS2_DAT  = 1'b1;
    logic        code_ack = 1'b0;
    logic        code_valid;
    logic [10:0] frame;
    logic [7:0]  scancode;
    logic        is_break;
    logic        is_extended;
    logic        frame_err;
    logic        overrun;

    ps2_frame_sequencer #(
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (8)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .PS2_CLK     (PS2_CLK),
        .PS2_DAT     (PS2_DAT),
        .code_ack    (code_ack),
        .code_valid  (code_valid),
        .frame       (frame),
        .scancode    (scancode),
        .is_break    (is_break),
        .is_extended (is_extended),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Event / error monitor
    int          evt_cnt    = 0;
    int          err_cycles = 0;
    int          err_pulses = 0;
    logic        cv_prev    = 1'b0;
    logic        fe_prev    = 1'b0;
    logic [10:0] ev_frame   = '0;
    logic [7:0]  ev_code    = '0;
    logic        ev_brk     = 1'b0;
    logic        ev_ext     = 1'b0;

    always @(negedge CLOCK_50) begin
        if (code_valid && !cv_prev) begin
            evt_cnt++;
            ev_frame = frame;
            ev_code  = scancode;
            ev_brk   = is_break;
            ev_ext   = is_extended;
        end
        if (frame_err) err_cycles++;
        if (frame_err && !fe_prev) err_pulses++;
        cv_prev = code_valid;
        fe_prev = frame_err;
    end

    task automatic ps2_bit(input logic b);
        @(posedge CLOCK_50); #1 PS2_DAT = b;
        repeat (HALF) @(posedge CLOCK_50);
        #1 PS2_CLK = 1'b0;
        repeat (HALF) @(posedge CLOCK_50);
        #1 PS2_CLK = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
        repeat (HALF) @(posedge CLOCK_50);
    endtask

    int e0;
    int p0;
    int c0;

    initial begin
        // Reset state
        repeat (3) @(posedge CLOCK_50);
        #1 chk("reset_outputs",
               32'({code_valid, frame, scancode, is_break, is_extended, frame_err, overrun}), 32'h0);
        resetn = 1'b1;
        repeat (10) @(posedge CLOCK_50);

        // 1: 0x23 with ack held high, latency from stop-bit pin edge
        code_ack = 1'b1;
        e0 = evt_cnt;
        for (int i = 0; i < 10; i++) ps2_bit(F_23[i]);
        @(posedge CLOCK_50); #1 PS2_DAT = 1'b1;
        repeat (HALF) @(posedge CLOCK_50);
        #1 PS2_CLK = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1 chk("t1_valid_early", 32'(code_valid), 32'h0);
        @(posedge CLOCK_50);
        #1 chk("t1_valid_n2", 32'(code_valid), 32'h1);
        chk("t1_scancode", 32'(scancode), 32'h23);
        chk("t1_frame", 32'(frame), 32'h446);
        chk("t1_flags", 32'({is_break, is_extended}), 32'h0);
        @(posedge CLOCK_50);
        #1 chk("t1_valid_drop", 32'(code_valid), 32'h0);
        repeat (HALF - 5) @(posedge CLOCK_50);
        #1 PS2_CLK = 1'b1;
        repeat (HALF) @(posedge CLOCK_50);
        chk("t1_events", 32'(evt_cnt - e0), 32'h1);

        // 2: F0 prefix then 0x4B
        e0 = evt_cnt;
        send_bits(F_F0, 11);
        chk("t2_no_evt_f0", 32'(evt_cnt - e0), 32'h0);
        send_bits(F_4B, 11);
        chk("t2_events", 32'(evt_cnt - e0), 32'h1);
        chk("t2_scancode", 32'(ev_code), 32'h4B);
        chk("t2_frame", 32'(ev_frame), 32'h696);
        chk("t2_break", 32'(ev_brk), 32'h1);
        chk("t2_ext", 32'(ev_ext), 32'h0);

        // 3: bad parity, then good 0x4B
        e0 = evt_cnt; p0 = err_pulses; c0 = err_cycles;
        send_bits(F_23_BAD, 11);
        chk("t3_err_pulses", 32'(err_pulses - p0), 32'h1);
        chk("t3_err_cycles", 32'(err_cycles - c0), 32'h1);
        chk("t3_no_evt", 32'(evt_cnt - e0), 32'h0);
        send_bits(F_4B, 11);
        chk("t3_events", 32'(evt_cnt - e0), 32'h1);
        chk("t3_scancode", 32'(ev_code), 32'h4B);
        chk("t3_break", 32'(ev_brk), 32'h0);

        // 4: partial frame timeout
        e0 = evt_cnt; p0 = err_pulses; c0 = err_cycles;
        send_bits(F_23, 5);
        repeat (100) @(posedge CLOCK_50);
        chk("t4_no_err_early", 32'(err_pulses - p0), 32'h0);
        repeat (150) @(posedge CLOCK_50);
        chk("t4_timeout_pulse", 32'(err_pulses - p0), 32'h1);
        chk("t4_timeout_cycles", 32'(err_cycles - c0), 32'h1);
        send_bits(F_23, 11);
        chk("t4_events", 32'(evt_cnt - e0), 32'h1);
        chk("t4_scancode", 32'(ev_code), 32'h23);
        chk("t4_frame", 32'(ev_frame), 32'h446);

        // 5: overrun with ack low
        code_ack = 1'b0;
        e0 = evt_cnt;
        send_bits(F_23, 11);
        #1 chk("t5_valid", 32'(code_valid), 32'h1);
        chk("t5_scancode", 32'(scancode), 32'h23);
        chk("t5_overrun_clear", 32'(overrun), 32'h0);
        send_bits(F_4B, 11);
        #1 chk("t5_held_scancode", 32'(scancode), 32'h23);
        chk("t5_held_frame", 32'(frame), 32'h446);
        chk("t5_overrun", 32'(overrun), 32'h1);
        chk("t5_still_valid", 32'(code_valid), 32'h1);
        chk("t5_events", 32'(evt_cnt - e0), 32'h1);
        @(posedge CLOCK_50); #1 code_ack = 1'b1;
        @(posedge CLOCK_50);
        #1 chk("t5_ack_drop", 32'(code_valid), 32'h0);
        code_ack = 1'b0;
        chk("t5_overrun_sticky", 32'(overrun), 32'h1);

        // 6: reset in the middle of an E0 prefix
        for (int i = 0; i < 6; i++) ps2_bit(F_E0[i]);
        PS2_DAT = 1'b1;
        @(posedge CLOCK_50); #1 resetn = 1'b0;
        #1 chk("t6_reset_outputs",
               32'({code_valid, frame, scancode, is_break, is_extended, frame_err, overrun}), 32'h0);
        repeat (5) @(posedge CLOCK_50);
        #1 resetn = 1'b1;
        repeat (10) @(posedge CLOCK_50);
        send_bits(F_75, 11);
        #1 chk("t6_valid", 32'(code_valid), 32'h1);
        chk("t6_scancode", 32'(scancode), 32'h75);
        chk("t6_frame", 32'(frame), 32'h4EA);
        chk("t6_ext_lost", 32'(is_extended), 32'h0);
        chk("t6_break", 32'(is_break), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
